axil_req_arbiter: RTL and testbench
===================================

AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter
Interface
REQ-001 SHALL have parameter C_ADDR_WIDTH, default 4, meaning AXI4-Lite byte-address width, covering 4 x 32-bit slave registers.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the abort threshold in cycles; used only with AXIL_ARB_TIMEOUT_EN.
REQ-003 SHALL have ACLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have ARESETN  input  1  asynchronous active-low reset.
REQ-005 SHALL have req_valid  input  2  per-requester request valid, bit n = requester n.
REQ-006 SHALL have req_write  input  2  per-requester 1=write, 0=read.
REQ-007 SHALL have req_addr  input  2*C_ADDR_WIDTH  per-requester byte address, requester n at slice n.
REQ-008 SHALL have req_wdata  input  64  per-requester write data, 32 bits each.
REQ-009 SHALL have req_ready  output  2  one-hot, one-cycle grant/accept pulse.
REQ-010 SHALL have rsp_valid  output  2  one-hot, one-cycle completion pulse.
REQ-011 SHALL have rsp_rdata  output  32  read data, shared; 0 for writes.
REQ-012 SHALL have rsp_resp  output  2  AXI response code, shared.
REQ-013 SHALL have m_axi_awaddr  output  C_ADDR_WIDTH  write address.
REQ-014 SHALL have m_axi_awvalid  output  1  write-address valid.
REQ-015 SHALL have m_axi_awready  input  1  write-address ready.
REQ-016 SHALL have m_axi_wdata  output  32  write data.
REQ-017 SHALL have m_axi_wstrb  output  4  write strobes, constant 4'hF.
REQ-018 SHALL have m_axi_wvalid  output  1  write-data valid.
REQ-019 SHALL have m_axi_wready  input  1  write-data ready.
REQ-020 SHALL have m_axi_bresp  input  2  write response.
REQ-021 SHALL have m_axi_bvalid  input  1  write-response valid.
REQ-022 SHALL have m_axi_bready  output  1  write-response ready.
REQ-023 SHALL have m_axi_araddr  output  C_ADDR_WIDTH  read address.
REQ-024 SHALL have m_axi_arvalid  output  1  read-address valid.
REQ-025 SHALL have m_axi_arready  input  1  read-address ready.
REQ-026 SHALL have m_axi_rdata  input  32  read data.
REQ-027 SHALL have m_axi_rresp  input  2  read response.
REQ-028 SHALL have m_axi_rvalid  input  1  read-data valid.
REQ-029 SHALL have m_axi_rready  output  1  read-data ready.
Function
REQ-030 SHALL implement states IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA and RESP, with exactly one AXI transaction outstanding at any time.
REQ-031 In IDLE with any req_valid set, SHALL grant: single request wins; on a tie, the requester not granted last wins (round-robin); pulse req_ready[g] for that cycle; capture write, addr and wdata; go to WR_ADDR or RD_ADDR.
REQ-032 WR_ADDR SHALL assert awvalid and wvalid from the cycle after the grant, drop each independently on its own handshake (simultaneous or either order), and enter WR_RESP once both have completed.
REQ-033 WR_RESP SHALL hold bready=1 and, on bvalid, capture bresp, set rdata to 0 and go to RESP; RD_ADDR SHALL hold arvalid until arready, then RD_DATA holds rready=1 and captures rdata/rresp on rvalid.
REQ-034 RESP SHALL pulse rsp_valid[g] for exactly one cycle with rsp_rdata and rsp_resp valid, then return to IDLE; rsp_rdata and rsp_resp hold until the next completion; responses are not backpressured.
REQ-035 Minimum latency SHALL be 3 cycles from the req_ready pulse to rsp_valid when the slave handshakes immediately; a new grant is possible the cycle after RESP.
REQ-036 A req_valid deasserted before its grant SHALL issue no transaction; requester inputs are sampled only on the grant cycle.
REQ-037 AXI valid signals SHALL never drop before their handshake, except on reset or timeout abort.
Reset
REQ-038 On ARESETN low, SHALL asynchronously enter IDLE with all valid, ready and rsp outputs at 0, rsp_rdata=0 and rsp_resp=0, and set last-grant to requester 1 so requester 0 wins the first tie; an in-flight transaction is dropped with no rsp_valid pulse.
Configuration
REQ-039 With AXIL_ARB_TIMEOUT_EN defined, a counter SHALL run in WR_ADDR, WR_RESP, RD_ADDR and RD_DATA and reset on every state change; reaching TIMEOUT_CYCLES SHALL drop all AXI valid/ready outputs and go to RESP with rsp_resp=2'b10 and rsp_rdata=0.
REQ-040 Without AXIL_ARB_TIMEOUT_EN, SHALL contain no counter, wait indefinitely for the slave, and ignore TIMEOUT_CYCLES.
Verification
REQ-041 SHALL verify: requester 0 writes 0x1..0x4 to 0x0,0x4,0x8,0xC, then reads them back -> rsp_rdata 0x1..0x4, rsp_resp 0 each time.
REQ-042 SHALL verify: both requesters assert together from reset, 4 times -> grants in order 0,1,0,1 and each rsp_valid matches its grant.
REQ-043 SHALL verify: slave awready 3 cycles before wready, then the reverse -> a single write each, WR_RESP entered only after both handshakes.
REQ-044 SHALL verify: ARESETN pulsed low while in RD_DATA -> all outputs 0 immediately, no rsp_valid, next tie granted to requester 0.
REQ-045 SHALL verify: with AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never asserts arready -> rsp_resp=2'b10 exactly 8 cycles after arvalid rises, arvalid low.

Source files
------------

// File: rtl/axil_req_arbiter.sv
// rtl/axil_req_arbiter.sv - two-requester round-robin AXI4-Lite master, one transaction in flight
// Optional abort timer enabled by AXIL_ARB_TIMEOUT_EN.
module axil_req_arbiter #(
    parameter int C_ADDR_WIDTH   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [2*C_ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]               req_wdata,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [C_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        RESP
    } state_t;

    state_t                  state, state_next;
    logic                    gnt_q;
    logic [C_ADDR_WIDTH-1:0] cap_addr_q;
    logic [31:0]             cap_wdata_q;
    logic                    aw_done_q, w_done_q;
    logic [31:0]             rdata_q;
    logic [1:0]              resp_q;

    logic any_req, gnt_sel;
    logic aw_hs, w_hs, aw_ok, w_ok;
    logic tmo;

    assign any_req = |req_valid;
    // gnt_q doubles as the round-robin pointer: on a tie the other requester wins
    assign gnt_sel = (&req_valid) ? ~gnt_q : req_valid[1];

    assign m_axi_awaddr  = cap_addr_q;
    assign m_axi_araddr  = cap_addr_q;
    assign m_axi_wdata   = cap_wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_awvalid = (state == WR_ADDR) && !aw_done_q;
    assign m_axi_wvalid  = (state == WR_ADDR) && !w_done_q;
    assign m_axi_bready  = (state == WR_RESP);
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_DATA);

    assign rsp_valid = (state == RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign aw_ok = aw_done_q || aw_hs;
    assign w_ok  = w_done_q || w_hs;

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             busy;

    assign busy = (state == WR_ADDR) || (state == WR_RESP) ||
                  (state == RD_ADDR) || (state == RD_DATA);
    assign tmo  = busy && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            tmo_cnt_q <= '0;
        end else if (!busy || (state_next != state)) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready  = gnt_sel ? 2'b10 : 2'b01;
                    state_next = req_write[gnt_sel] ? WR_ADDR : RD_ADDR;
                end
            end
            WR_ADDR: if (aw_ok && w_ok)   state_next = WR_RESP;
            WR_RESP: if (m_axi_bvalid)    state_next = RESP;
            RD_ADDR: if (m_axi_arready)   state_next = RD_DATA;
            RD_DATA: if (m_axi_rvalid)    state_next = RESP;
            RESP:                         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
        if (tmo) state_next = RESP;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            gnt_q       <= 1'b1;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= 2'b00;
        end else begin
            state <= state_next;
            if ((state == IDLE) && any_req) begin
                gnt_q       <= gnt_sel;
                cap_addr_q  <= gnt_sel ? req_addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH]
                                       : req_addr[C_ADDR_WIDTH-1:0];
                cap_wdata_q <= gnt_sel ? req_wdata[63:32] : req_wdata[31:0];
            end
            // Handshake flags live only while the write phase is still open
            aw_done_q <= (state == WR_ADDR) && (state_next == WR_ADDR) && aw_ok;
            w_done_q  <= (state == WR_ADDR) && (state_next == WR_ADDR) && w_ok;
            if (tmo) begin
                rdata_q <= '0;
                resp_q  <= 2'b10;
            end else if ((state == WR_RESP) && m_axi_bvalid) begin
                rdata_q <= '0;
                resp_q  <= m_axi_bresp;
            end else if ((state == RD_DATA) && m_axi_rvalid) begin
                rdata_q <= m_axi_rdata;
                resp_q  <= m_axi_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb/tb_axil_req_arbiter.sv - directed bench for axil_req_arbiter with a small AXI4-Lite slave model
module tb_axil_req_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [1:0]  req_valid = '0, req_write = '0;
    logic [7:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [1:0]  req_ready, rsp_valid, rsp_resp;
    logic [31:0] rsp_rdata;
    logic [3:0]  m_axi_awaddr, m_axi_araddr, m_axi_wstrb;
    logic [31:0] m_axi_wdata;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0;
    logic        m_axi_arready = 0, m_axi_rvalid = 0;
    logic [1:0]  m_axi_bresp = 0, m_axi_rresp = 0;
    logic [31:0] m_axi_rdata = 0;

    int checks = 0, errors = 0;
    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    bit ar_never = 0, r_hold = 0;
    logic [31:0] mem [4];
    bit aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
    logic [3:0]  aw_a = 0, ar_a = 0;
    logic [31:0] w_d = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0;
    int aw_cnt = 0, w_cnt = 0, bready_cyc = 0, rsp_pulses = 0;

    axil_req_arbiter #(.C_ADDR_WIDTH(4), .TIMEOUT_CYCLES(8)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave decides ready/valid on the falling edge, so a handshake it sets up fires on the next rising edge
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
            aw_wait = 0; w_wait = 0; ar_wait = 0;
        end else begin
            bready_cyc += int'(m_axi_bready);
            if (rsp_valid != 2'b00) rsp_pulses++;
            if (b_fire) begin m_axi_bvalid = 0; b_fire = 0; end
            if (!m_axi_bvalid && aw_got && w_got) begin
                mem[aw_a[3:2]] = w_d; aw_got = 0; w_got = 0;
                m_axi_bvalid = 1; m_axi_bresp = 2'b00;
            end
            if (m_axi_bvalid && m_axi_bready) b_fire = 1;
            if (r_fire) begin m_axi_rvalid = 0; r_fire = 0; end
            if (!m_axi_rvalid && ar_got && !r_hold) begin
                m_axi_rvalid = 1; m_axi_rdata = mem[ar_a[3:2]]; m_axi_rresp = 2'b00; ar_got = 0;
            end
            if (m_axi_rvalid && m_axi_rready) r_fire = 1;
            if (m_axi_awvalid && aw_wait >= aw_delay) begin
                m_axi_awready = 1; aw_a = m_axi_awaddr; aw_got = 1; aw_cnt++;
            end else begin
                m_axi_awready = 0; aw_wait = m_axi_awvalid ? aw_wait + 1 : 0;
            end
            if (m_axi_wvalid && w_wait >= w_delay) begin
                m_axi_wready = 1; w_d = m_axi_wdata; w_got = 1; w_cnt++;
            end else begin
                m_axi_wready = 0; w_wait = m_axi_wvalid ? w_wait + 1 : 0;
            end
            if (m_axi_arvalid && !ar_never && ar_wait >= ar_delay) begin
                m_axi_arready = 1; ar_a = m_axi_araddr; ar_got = 1;
            end else begin
                m_axi_arready = 0; ar_wait = m_axi_arvalid ? ar_wait + 1 : 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge ACLK); ARESETN = 0;
        @(negedge ACLK); ARESETN = 1;
    endtask

    // lat counts falling edges from the one that sees req_ready to the one that sees rsp_valid
    task automatic run_req(input logic [1:0] v, input logic [1:0] wr, input logic [7:0] a,
                           input logic [63:0] d, output int g, output int lat,
                           output logic [31:0] rd, output logic [1:0] rs);
        int n = 0;
        g = -1; lat = -1; rd = 'x; rs = 'x;
        @(negedge ACLK); req_valid = v; req_write = wr; req_addr = a; req_wdata = d; #1;
        while (req_ready == 2'b00 && n < 50) begin @(negedge ACLK); #1; n++; end
        check("grant_seen", req_ready != 2'b00, 1'b1);
        if (req_ready == 2'b00) begin req_valid = 0; return; end
        g = int'(req_ready[1]);
        @(negedge ACLK); req_valid = 0; #1; lat = 1;
        while (rsp_valid == 2'b00 && lat < 100) begin @(negedge ACLK); #1; lat++; end
        check("rsp_seen", rsp_valid != 2'b00, 1'b1);
        check("rsp_owner", rsp_valid, (g == 1) ? 2'b10 : 2'b01);
        rd = rsp_rdata; rs = rsp_resp;
        @(negedge ACLK); #1;
        check("rsp_one_cycle", rsp_valid, 2'b00);
    endtask

    initial begin
        int g, lat, a0, w0, b0, p0;
        logic [31:0] rd;
        logic [1:0]  rs;
        for (int i = 0; i < 4; i++) mem[i] = 32'hDEAD_0000;
        #1;
        check("reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_resp, m_axi_awvalid,
              m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        check("wstrb", m_axi_wstrb, 4'hF);
        do_reset();

        for (int i = 0; i < 4; i++) begin
            run_req(2'b01, 2'b01, 8'(i * 4), 64'(i + 1), g, lat, rd, rs);
            check("wr_grant", g, 0);
            check("wr_latency", lat, 3);
            check("wr_rdata", rd, 0);
            check("wr_resp", rs, 0);
        end
        for (int i = 0; i < 4; i++) begin
            run_req(2'b01, 2'b00, 8'(i * 4), 64'h0, g, lat, rd, rs);
            check("rd_latency", lat, 3);
            check("rd_rdata", rd, 32'(i + 1));
            check("rd_resp", rs, 0);
        end

        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 0 : 3;
            w_delay  = (k == 0) ? 3 : 0;
            a0 = aw_cnt; w0 = w_cnt; b0 = bready_cyc;
            run_req(2'b01, 2'b01, (k == 0) ? 8'h08 : 8'h0C, (k == 0) ? 64'hA5 : 64'h5A,
                    g, lat, rd, rs);
            check("skew_latency", lat, 6);
            check("skew_aw_once", aw_cnt - a0, 1);
            check("skew_w_once", w_cnt - w0, 1);
            check("skew_bready_cycles", bready_cyc - b0, 1);
            check("skew_resp", rs, 0);
        end
        aw_delay = 0; w_delay = 0;
        run_req(2'b01, 2'b00, 8'h08, 64'h0, g, lat, rd, rs);
        check("skew_readback_a", rd, 32'hA5);
        run_req(2'b01, 2'b00, 8'h0C, 64'h0, g, lat, rd, rs);
        check("skew_readback_b", rd, 32'h5A);

        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_req(2'b11, 2'b00, 8'h40, 64'h0, g, lat, rd, rs);
            check("tie_grant", g, k % 2);
            check("tie_rdata", rd, (k % 2 == 0) ? 32'h1 : 32'h2);
        end

        r_hold = 1;
        @(negedge ACLK); req_valid = 2'b01; req_write = 2'b00; req_addr = 8'h00; #1;
        check("hold_grant", req_ready, 2'b01);
        @(negedge ACLK); req_valid = 0; #1;
        @(negedge ACLK); #1;
        check("in_rd_data", {m_axi_arvalid, m_axi_rready}, 2'b01);
        p0 = rsp_pulses;
        #2 ARESETN = 0; #1;
        check("async_reset_outputs", {req_ready, rsp_valid, rsp_rdata, rsp_resp, m_axi_awvalid,
              m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 0);
        @(negedge ACLK); #1 ARESETN = 1; r_hold = 0;
        repeat (3) @(negedge ACLK);
        check("no_rsp_after_reset", rsp_pulses, p0);
        run_req(2'b11, 2'b00, 8'h40, 64'h0, g, lat, rd, rs);
        check("post_reset_tie", g, 0);
        check("post_reset_rdata", rd, 32'h1);

`ifdef AXIL_ARB_TIMEOUT_EN
        ar_never = 1;
        run_req(2'b01, 2'b00, 8'h04, 64'h0, g, lat, rd, rs);
        check("tmo_latency", lat, 9);
        check("tmo_resp", rs, 2'b10);
        check("tmo_rdata", rd, 0);
        check("tmo_arvalid_low", m_axi_arvalid, 0);
        ar_never = 0;
        run_req(2'b01, 2'b00, 8'h04, 64'h0, g, lat, rd, rs);
        check("after_tmo_rdata", rd, 32'h2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
